// File: rtl/execute_stage.sv
// LC-3 execute stage: operand bypass, ALU, address generation, and the
// pipeline registers feeding memaccess/writeback and the controller.
module execute_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_execute,
  input  logic [WIDTH-1:0] IR,
  input  logic [WIDTH-1:0] npc_in,
  input  logic [5:0]       E_Control,
  input  logic [1:0]       W_Control_in,
  input  logic             Mem_Control_in,
  input  logic [WIDTH-1:0] VSR1,
  input  logic [WIDTH-1:0] VSR2,
  input  logic             bypass_alu_1,
  input  logic             bypass_alu_2,
  input  logic             bypass_mem_1,
  input  logic             bypass_mem_2,
  input  logic [WIDTH-1:0] Mem_Bypass_Val,
  output logic [2:0]       sr1,
  output logic [2:0]       sr2,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] pcout,
  output logic [2:0]       dr,
  output logic [WIDTH-1:0] M_Data,
  output logic [2:0]       NZP,
  output logic [WIDTH-1:0] IR_Exec,
  output logic [1:0]       W_Control_out,
  output logic             Mem_Control_out
);

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
    OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
    OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_LEA = 4'b1110
  } opcode_t;

  opcode_t          op;
  logic [1:0]       alu_control;
  logic [1:0]       pcselect1;
  logic             pcselect2;
  logic             op2select;
  logic             is_alu;
  logic             is_store;
  logic             writes_dr;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] pc_result;
  logic [2:0]       dr_next;
  logic [2:0]       nzp_next;

  assign {alu_control, pcselect1, pcselect2, op2select} = E_Control;
  assign op = opcode_t'(IR[15:12]);

  always_comb begin
    is_alu    = 1'b0;
    is_store  = 1'b0;
    writes_dr = 1'b0;
    nzp_next  = '0;
    case (op)
      OP_ADD, OP_AND, OP_NOT: begin
        is_alu    = 1'b1;
        writes_dr = 1'b1;
      end
      OP_LD, OP_LDR, OP_LDI, OP_LEA: writes_dr = 1'b1;
      OP_ST, OP_STR, OP_STI:         is_store  = 1'b1;
      OP_BR:                         nzp_next  = IR[11:9];
      OP_JMP:                        nzp_next  = 3'b111;
      default: ;
    endcase
    dr_next = writes_dr ? IR[11:9] : 3'b000;
  end

  assign sr1 = IR[8:6];
  assign sr2 = is_store ? IR[11:9] : IR[2:0];

  // The ALU bypass takes priority over the memory bypass.
  always_comb begin
    val1 = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
    val2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
    op2  = op2select ? {{(WIDTH-5){IR[4]}}, IR[4:0]} : val2;
  end

  always_comb begin
    case (alu_control)
      2'd1:    alu_result = val1 & op2;
      2'd2:    alu_result = ~val1;
      default: alu_result = val1 + op2;
    endcase
  end

  always_comb begin
    case (pcselect1)
      2'd0:    offset = {{(WIDTH-11){IR[10]}}, IR[10:0]};
      2'd1:    offset = {{(WIDTH-9){IR[8]}}, IR[8:0]};
      2'd2:    offset = {{(WIDTH-6){IR[5]}}, IR[5:0]};
      default: offset = '0;
    endcase
    base      = pcselect2 ? npc_in : val1;
    pc_result = base + offset;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout          <= '0;
      pcout           <= '0;
      dr              <= '0;
      M_Data          <= '0;
      NZP             <= '0;
      IR_Exec         <= '0;
      W_Control_out   <= '0;
      Mem_Control_out <= 1'b0;
    end else if (enable_execute) begin
      if (is_alu) aluout <= alu_result;
      pcout           <= pc_result;
      dr              <= dr_next;
      M_Data          <= val2;
      NZP             <= nzp_next;
      IR_Exec         <= IR;
      W_Control_out   <= W_Control_in;
      Mem_Control_out <= Mem_Control_in;
    end
  end

endmodule
